// File: rtl/gpc_axil_regbank_pkg.sv
// rtl/gpc_axil_regbank_pkg.sv - register map, bit indices, stream states and response codes
package gpc_axil_regbank_pkg;

    localparam logic [11:0] ADDR_CTRL      = 12'h000;
    localparam logic [11:0] ADDR_STATUS    = 12'h008;
    localparam logic [11:0] ADDR_RX_FRAMES = 12'h010;
    localparam logic [11:0] ADDR_RX_BYTES  = 12'h018;
    localparam logic [11:0] ADDR_TX_FRAMES = 12'h020;
    localparam logic [11:0] ADDR_INJ_KEEP  = 12'h028;
    // CAP and INJ arrays each occupy one 256-byte page: 0x100 and 0x200
    localparam int CAP_PAGE = 1;
    localparam int INJ_PAGE = 2;

    localparam int CTRL_INJ_GO    = 0;
    localparam int CTRL_CAP_ARM   = 1;
    localparam int CTRL_CNT_CLR   = 2;
    localparam int STAT_INJ_BUSY  = 0;
    localparam int STAT_CAP_VALID = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        INJ  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/gpc_axil_slave_if.sv
// rtl/gpc_axil_slave_if.sv - AXI-Lite handshake front-end producing single-cycle register access strobes
module gpc_axil_slave_if
    import gpc_axil_regbank_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 64,
    parameter int AXIL_DATA_WIDTH = 64,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic                       wr_en,
    output logic [AXIL_ADDR_WIDTH-1:0] wr_addr,
    output logic [AXIL_DATA_WIDTH-1:0] wr_data,
    output logic [AXIL_STRB_WIDTH-1:0] wr_strb,
    input  logic                       wr_err,
    output logic                       rd_en,
    output logic [AXIL_ADDR_WIDTH-1:0] rd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0] rd_data,
    input  logic                       rd_err
);

    // Address and data are taken together; a pending response blocks the next write
    assign wr_en          = rst_n & s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid;
    assign s_axil_awready = wr_en;
    assign s_axil_wready  = wr_en;
    assign wr_addr        = s_axil_awaddr;
    assign wr_data        = s_axil_wdata;
    assign wr_strb        = s_axil_wstrb;

    assign s_axil_arready = rst_n & ~s_axil_rvalid;
    assign rd_en          = s_axil_arvalid & s_axil_arready;
    assign rd_addr        = s_axil_araddr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else if (wr_en) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (rd_en) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_data;
            s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/gpc_axil_stream_regbank.sv
// rtl/gpc_axil_stream_regbank.sv - AXI-Lite register bank with stream passthrough, capture and inject
// Optional: GPC_AXIL_REGBANK_SLVERR_EN makes RO/unmapped writes and unmapped reads answer SLVERR.
module gpc_axil_stream_regbank
    import gpc_axil_regbank_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 64,
    parameter int AXIL_DATA_WIDTH = 64,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);

    localparam int AW    = AXIL_ADDR_WIDTH;
    localparam int DW    = AXIL_DATA_WIDTH;
    localparam int SW    = AXIL_STRB_WIDTH;
    localparam int KW    = AXIS_KEEP_WIDTH;
    localparam int NW    = AXIS_DATA_WIDTH / AXIL_DATA_WIDTH;
    localparam int ALIGN = $clog2(SW);
    localparam int IDXW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW    = $clog2(KW + 1);
    localparam logic [DW-1:0] KEEP_MASK =
        (KW >= DW) ? {DW{1'b1}} : ({DW{1'b1}} >> (DW - KW));

    logic          wr_en, rd_en, wr_err, rd_err;
    logic [AW-1:0] wr_addr, rd_addr, wa, ra;
    logic [DW-1:0] wr_data, rd_data, wmask;
    logic [SW-1:0] wr_strb;

    gpc_axil_slave_if #(
        .AXIL_ADDR_WIDTH(AW),
        .AXIL_DATA_WIDTH(DW),
        .AXIL_STRB_WIDTH(SW)
    ) u_slave_if (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
    );

    stream_state_t state, state_n;
    logic [DW-1:0] rx_frames, rx_bytes, tx_frames, inj_keep;
    logic [DW-1:0] cap_regs [NW];
    logic [DW-1:0] inj_regs [NW];
    logic [AXIS_DATA_WIDTH-1:0] inj_flat;
    logic          cap_arm, cap_valid, inj_busy;
    logic [CW-1:0] keep_cnt;

    assign wa = {wr_addr[AW-1:ALIGN], {ALIGN{1'b0}}};
    assign ra = {rd_addr[AW-1:ALIGN], {ALIGN{1'b0}}};

    logic            w_ctrl, w_keep, w_inj, wr_hit_rw, r_cap, r_inj, rd_hit;
    logic [IDXW-1:0] wa_idx, ra_idx;
    assign wa_idx    = wa[ALIGN +: IDXW];
    assign ra_idx    = ra[ALIGN +: IDXW];
    assign w_ctrl    = (wa == AW'(ADDR_CTRL));
    assign w_keep    = (wa == AW'(ADDR_INJ_KEEP));
    assign w_inj     = (wa[AW-1:8] == (AW-8)'(INJ_PAGE)) && ({1'b0, wa[7:0]} < 9'(NW * SW));
    assign r_cap     = (ra[AW-1:8] == (AW-8)'(CAP_PAGE)) && ({1'b0, ra[7:0]} < 9'(NW * SW));
    assign r_inj     = (ra[AW-1:8] == (AW-8)'(INJ_PAGE)) && ({1'b0, ra[7:0]} < 9'(NW * SW));
    assign wr_hit_rw = w_ctrl | w_keep | w_inj;

    // CTRL action bits only count when their byte lane is strobed
    logic inj_go, cap_set, cnt_clr, rx_hs, inj_done, cap_take;
    assign inj_go   = wr_en & w_ctrl & wr_strb[0] & wr_data[CTRL_INJ_GO];
    assign cap_set  = wr_en & w_ctrl & wr_strb[0] & wr_data[CTRL_CAP_ARM];
    assign cnt_clr  = wr_en & w_ctrl & wr_strb[0] & wr_data[CTRL_CNT_CLR];
    assign rx_hs    = s_axis_tvalid & s_axis_tready;
    assign inj_done = (state == INJ) & m_axis_tready;
    assign cap_take = cap_arm & (state == IDLE) & rx_hs;

`ifdef GPC_AXIL_REGBANK_SLVERR_EN
    assign wr_err = ~wr_hit_rw;
    assign rd_err = ~rd_hit;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, wr_addr[ALIGN-1:0], rd_addr[ALIGN-1:0],
                         rd_en, rd_hit, wr_hit_rw};

    always_comb begin
        wmask    = '0;
        keep_cnt = '0;
        for (int b = 0; b < SW; b++) wmask[b*8 +: 8] = {8{wr_strb[b]}};
        for (int k = 0; k < KW; k++) keep_cnt = keep_cnt + CW'(s_axis_tkeep[k]);
    end

    for (genvar g = 0; g < NW; g++) begin : g_inj_flat
        assign inj_flat[g*DW +: DW] = inj_regs[g];
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [DW-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        if (ra == AW'(ADDR_CTRL)) begin
            rd_data[CTRL_CAP_ARM] = cap_arm;
        end else if (ra == AW'(ADDR_STATUS)) begin
            rd_data[STAT_INJ_BUSY]  = inj_busy;
            rd_data[STAT_CAP_VALID] = cap_valid;
        end else if (ra == AW'(ADDR_RX_FRAMES)) rd_data = rx_frames;
        else if (ra == AW'(ADDR_RX_BYTES))  rd_data = rx_bytes;
        else if (ra == AW'(ADDR_TX_FRAMES)) rd_data = tx_frames;
        else if (ra == AW'(ADDR_INJ_KEEP))  rd_data = inj_keep;
        else if (r_cap)                     rd_data = cap_regs[ra_idx];
        else if (r_inj)                     rd_data = inj_regs[ra_idx];
        else                                rd_hit  = 1'b0;
    end

    // IDLE marks a frame boundary: a pending inject is taken before any new RX frame
    always_comb begin
        state_n       = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            IDLE, PASS: begin
                if (state == IDLE && inj_busy) begin
                    state_n = INJ;
                end else begin
                    s_axis_tready = m_axis_tready;
                    m_axis_tvalid = s_axis_tvalid;
                    m_axis_tdata  = s_axis_tdata;
                    m_axis_tkeep  = s_axis_tkeep;
                    m_axis_tlast  = s_axis_tlast;
                    if (s_axis_tvalid && m_axis_tready) state_n = s_axis_tlast ? IDLE : PASS;
                end
            end
            INJ: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = inj_flat;
                m_axis_tkeep  = KW'(inj_keep);
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!rst_n) begin
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b0;
            m_axis_tdata  = '0;
            m_axis_tkeep  = '0;
            m_axis_tlast  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_frames <= '0;
            rx_bytes  <= '0;
            tx_frames <= '0;
            inj_keep  <= '0;
            cap_arm   <= 1'b0;
            cap_valid <= 1'b0;
            inj_busy  <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                cap_regs[i] <= '0;
                inj_regs[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (cnt_clr) begin
                rx_frames <= '0;
                rx_bytes  <= '0;
                tx_frames <= '0;
            end else begin
                if (rx_hs) begin
                    rx_bytes <= rx_bytes + DW'(keep_cnt);
                    if (s_axis_tlast) rx_frames <= rx_frames + 1'b1;
                end
                if (inj_done) tx_frames <= tx_frames + 1'b1;
            end
            if (inj_go && !inj_busy) inj_busy <= 1'b1;
            else if (inj_done)       inj_busy <= 1'b0;
            if (cap_take) begin
                for (int i = 0; i < NW; i++) cap_regs[i] <= s_axis_tdata[i*DW +: DW];
                cap_valid <= 1'b1;
                cap_arm   <= 1'b0;
            end
            if (cap_set) begin
                cap_arm   <= 1'b1;
                cap_valid <= 1'b0;
            end
            // Inject frame is frozen while a send is pending
            if (wr_en && !inj_busy) begin
                if (w_keep) inj_keep <= merge(inj_keep, wr_data, wmask) & KEEP_MASK;
                if (w_inj)  inj_regs[wa_idx] <= merge(inj_regs[wa_idx], wr_data, wmask);
            end
        end
    end

endmodule

// File: tb/tb_gpc_axil_stream_regbank.sv
// tb/tb_gpc_axil_stream_regbank.sv - scoreboard bench for gpc_axil_stream_regbank
module tb_gpc_axil_stream_regbank;

    localparam int AW = 64, DW = 64, SW = 8, XW = 512, KW = 64;
`ifdef GPC_AXIL_REGBANK_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] s_axil_awaddr = '0, s_axil_araddr = '0;
    logic [2:0]    s_axil_awprot = '0, s_axil_arprot = '0;
    logic          s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_bready = 1, s_axil_arvalid = 0, s_axil_rready = 1;
    logic [DW-1:0] s_axil_wdata = '0;
    logic [SW-1:0] s_axil_wstrb = '1;
    logic          s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
    logic [1:0]    s_axil_bresp, s_axil_rresp;
    logic [DW-1:0] s_axil_rdata;
    logic [XW-1:0] s_axis_tdata = '0, m_axis_tdata;
    logic [KW-1:0] s_axis_tkeep = '0, m_axis_tkeep;
    logic          s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready = 1;

    gpc_axil_stream_regbank dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr),
        .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    typedef struct { logic [XW-1:0] d; logic [KW-1:0] k; logic l; } beat_t;
    typedef struct { logic [DW-1:0] d; logic [1:0] r; } rd_t;
    beat_t      exp_tx[$];
    rd_t        exp_rd[$];
    logic [1:0] exp_b[$];
    beat_t      eb;
    rd_t        er;
    logic [1:0] ebr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL timeout %s: got no handshake, expected one within 50 cycles", name);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_tx.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL tx_unexpected: got beat %0h expected none", m_axis_tdata);
                end else begin
                    eb = exp_tx.pop_front();
                    chk("tx_data", m_axis_tdata, eb.d);
                    chk("tx_keep", m_axis_tkeep, eb.k);
                    chk("tx_last", m_axis_tlast, eb.l);
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (exp_rd.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rd_unexpected: got %0h expected none", s_axil_rdata);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rdata", s_axil_rdata, er.d);
                    chk("rresp", s_axil_rresp, er.r);
                end
            end
            if (s_axil_bvalid && s_axil_bready) begin
                if (exp_b.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL b_unexpected: got %0h expected none", s_axil_bresp);
                end else begin
                    ebr = exp_b.pop_front();
                    chk("bresp", s_axil_bresp, ebr);
                end
            end
        end
    end

    task automatic drain();
        int t = 0;
        while ((exp_tx.size() + exp_rd.size() + exp_b.size()) != 0 && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 50) tmo("drain");
    endtask

    task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] r);
        int t = 0;
        @(posedge clk); #1;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_awvalid = 1; s_axil_wvalid = 1;
        exp_b.push_back(r);
        @(negedge clk);
        while (!s_axil_awready && t < 50) begin @(negedge clk); t++; end
        if (!s_axil_awready) tmo("aw");
        @(posedge clk); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0;
        drain();
    endtask

    task automatic axil_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] r);
        int t = 0;
        rd_t e;
        @(posedge clk); #1;
        s_axil_araddr = a; s_axil_arvalid = 1;
        e.d = d; e.r = r;
        exp_rd.push_back(e);
        @(negedge clk);
        while (!s_axil_arready && t < 50) begin @(negedge clk); t++; end
        if (!s_axil_arready) tmo("ar");
        @(posedge clk); #1;
        s_axil_arvalid = 0;
        drain();
    endtask

    task automatic send_beat(input logic [XW-1:0] d, input logic [KW-1:0] k, input logic l);
        int t = 0;
        beat_t e;
        @(posedge clk); #1;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1;
        e.d = d; e.k = k; e.l = l;
        exp_tx.push_back(e);
        @(negedge clk);
        while (!s_axis_tready && t < 50) begin @(negedge clk); t++; end
        if (!s_axis_tready) tmo("s_axis");
        @(posedge clk); #1;
        s_axis_tvalid = 0; s_axis_tlast = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200us");
        $fatal(1);
    end

    logic [XW-1:0] a5_data, inj_data, pat;
    logic [DW-1:0] held;
    beat_t ib;

    initial begin
        a5_data  = {64{8'hA5}};
        inj_data = XW'(64'h1122334455667788);
        // 1. reset with upstream valid
        s_axis_tvalid = 1; s_axis_tdata = {64{8'h3C}}; s_axis_tkeep = '1;
        repeat (3) @(negedge clk);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_bvalid_rvalid", {s_axil_bvalid, s_axil_rvalid}, 0);
        @(posedge clk); #1;
        s_axis_tvalid = 0; rst_n = 1;
        axil_read(64'h00, 0, 2'b00);
        axil_read(64'h10, 0, 2'b00);
        axil_read(64'h28, 0, 2'b00);
        axil_read(64'h100, 0, 2'b00);

        // 2. passthrough 3-beat frame
        pat = {16{32'hC0DE0001}};
        send_beat(pat, '1, 0);
        send_beat(~pat, '1, 0);
        send_beat({16{32'h01234567}}, 64'h000000000000FFFF, 1);
        drain();
        axil_read(64'h10, 1, 2'b00);
        axil_read(64'h18, 144, 2'b00);
        axil_read(64'h20, 0, 2'b00);

        // 3. capture
        axil_write(64'h00, 64'h2, 2'b00);
        axil_read(64'h00, 64'h2, 2'b00);
        axil_read(64'h08, 64'h0, 2'b00);
        send_beat(a5_data, '1, 0);
        send_beat(pat, '1, 1);
        axil_read(64'h08, 64'h2, 2'b00);
        axil_read(64'h00, 64'h0, 2'b00);
        axil_read(64'h100, 64'hA5A5A5A5A5A5A5A5, 2'b00);
        axil_read(64'h138, 64'hA5A5A5A5A5A5A5A5, 2'b00);
        send_beat({64{8'h5A}}, '1, 1);
        axil_read(64'h100, 64'hA5A5A5A5A5A5A5A5, 2'b00);
        axil_read(64'h10, 3, 2'b00);
        axil_read(64'h18, 336, 2'b00);

        // 4. inject requested mid RX frame
        axil_write(64'h200, 64'h1122334455667788, 2'b00);
        axil_write(64'h28, 64'hFF, 2'b00);
        axil_read(64'h28, 64'hFF, 2'b00);
        send_beat(pat, '1, 0);
        axil_write(64'h00, 64'h1, 2'b00);
        axil_read(64'h08, 64'h3, 2'b00);
        chk("inj_waits_for_tlast", m_axis_tvalid, 0);
        send_beat(~pat, '1, 1);
        m_axis_tready = 0;
        ib.d = inj_data; ib.k = 64'hFF; ib.l = 1;
        exp_tx.push_back(ib);
        begin
            int t = 0;
            @(negedge clk);
            while (!m_axis_tvalid && t < 20) begin @(negedge clk); t++; end
            if (!m_axis_tvalid) tmo("inj_valid");
        end
        for (int i = 0; i < 5; i++) begin
            chk("inj_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                {1'b1, 1'b1, 64'hFF, inj_data});
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_axis_tready = 1;
        drain();
        axil_read(64'h20, 1, 2'b00);
        axil_read(64'h08, 64'h2, 2'b00);
        axil_read(64'h10, 4, 2'b00);

        // 5a. counter clear coincident with a tlast beat
        @(posedge clk); #1;
        s_axil_awaddr = 64'h00; s_axil_wdata = 64'h4; s_axil_awvalid = 1; s_axil_wvalid = 1;
        s_axis_tdata = pat; s_axis_tkeep = '1; s_axis_tlast = 1; s_axis_tvalid = 1;
        exp_b.push_back(2'b00);
        ib.d = pat; ib.k = '1; ib.l = 1;
        exp_tx.push_back(ib);
        @(negedge clk);
        chk("clr_coincident_ready", {s_axil_awready, s_axis_tready}, 2'b11);
        @(posedge clk); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axis_tvalid = 0; s_axis_tlast = 0;
        drain();
        axil_read(64'h10, 0, 2'b00);
        axil_read(64'h18, 0, 2'b00);
        axil_read(64'h20, 0, 2'b00);

        // 5b. INJ_GO while busy, and INJ write while busy is dropped
        m_axis_tready = 0;
        axil_write(64'h00, 64'h1, 2'b00);
        axil_write(64'h00, 64'h1, 2'b00);
        axil_write(64'h200, 64'hDEADBEEFDEADBEEF, 2'b00);
        ib.d = inj_data; ib.k = 64'hFF; ib.l = 1;
        exp_tx.push_back(ib);
        @(posedge clk); #1;
        m_axis_tready = 1;
        drain();
        repeat (10) @(negedge clk);
        axil_read(64'h20, 1, 2'b00);
        axil_read(64'h200, 64'h1122334455667788, 2'b00);

        // 5c. rready held low keeps rdata stable
        @(posedge clk); #1;
        s_axil_rready = 0; s_axil_araddr = 64'h28; s_axil_arvalid = 1;
        er.d = 64'hFF; er.r = 2'b00;
        exp_rd.push_back(er);
        @(posedge clk); #1;
        s_axil_arvalid = 0;
        held = s_axil_rdata;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd_hold", {s_axil_rvalid, s_axil_rdata}, {1'b1, 64'hFF});
        end
        chk("rd_hold_first", held, 64'hFF);
        @(posedge clk); #1;
        s_axil_rready = 1;
        drain();

        // 6. error responses
        axil_write(64'h10, 64'h55, ERR_RESP);
        axil_read(64'h3F8, 0, ERR_RESP);
        axil_read(64'h10, 0, 2'b00);

        repeat (5) @(negedge clk);
        chk("queues_drained", exp_tx.size() + exp_rd.size() + exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
